// File: rtl/draw_layer_arbiter.sv
// rtl/draw_layer_arbiter.sv - per-pixel layer priority arbiter with per-frame overlap flag handoff
//
// Ports:
//   clk, resetN          pixel clock, asynchronous active-low reset
//   startOfFrame         one-cycle pulse at the first pixel of each frame
//   drawReq, layerRGB    per-layer request and packed colour (layer i at [8*i+7:8*i])
//   BG_RGB               background colour for the current pixel
//   boardersDrawReq      background reports a border/bar pixel
//   RGBOut, winnerId     registered arbitration result (one cycle after the pixel inputs)
//   layerHitLayer        last frame: layer i overlapped any other layer
//   layerHitBorder       last frame: layer i overlapped a border pixel
//   collisionPulse       one-cycle pulse after a handoff with nonzero flags
//   frameCount           completed-frame counter, wraps
module draw_layer_arbiter #(
    parameter int          NUM_LAYERS  = 4,
    parameter logic [7:0]  TRANSPARENT = 8'hFF,
    parameter int          FRAME_CNT_W = 16,
    localparam int         ID_W        = $clog2(NUM_LAYERS + 1)
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic [NUM_LAYERS-1:0]   drawReq,
    input  logic [NUM_LAYERS*8-1:0] layerRGB,
    input  logic [7:0]              BG_RGB,
    input  logic                    boardersDrawReq,
    output logic [7:0]              RGBOut,
    output logic [ID_W-1:0]         winnerId,
    output logic [NUM_LAYERS-1:0]   layerHitLayer,
    output logic [NUM_LAYERS-1:0]   layerHitBorder,
    output logic                    collisionPulse,
    output logic [FRAME_CNT_W-1:0]  frameCount
);

    typedef enum logic {
        ACCUM   = 1'b0,
        HANDOFF = 1'b1
    } state_t;

    state_t                  state_q;
    logic [7:0]              rgb_q, rgb_d;
    logic [ID_W-1:0]         win_q, win_d;
    logic [NUM_LAYERS-1:0]   acc_layer_q, acc_border_q;
    logic [NUM_LAYERS-1:0]   hit_layer_q, hit_border_q;
    logic                    pulse_q;
    logic [FRAME_CNT_W-1:0]  fcnt_q;

    logic [NUM_LAYERS-1:0]   eff;
    logic [NUM_LAYERS-1:0]   cur_layer_hit;
    logic [NUM_LAYERS-1:0]   cur_border_hit;
    logic [NUM_LAYERS-1:0]   others;

    // A request carrying the transparent colour is treated as no pixel at all,
    // both for arbitration and for overlap detection.
    always_comb begin
        eff = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eff[i] = drawReq[i] && (layerRGB[8*i +: 8] != TRANSPARENT);
        end
    end

    always_comb begin
        cur_layer_hit  = '0;
        cur_border_hit = '0;
        others         = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            others            = eff;
            others[i]         = 1'b0;
            cur_layer_hit[i]  = eff[i] && (|others);
            cur_border_hit[i] = eff[i] && boardersDrawReq;
        end
    end

    // Scan from lowest priority upward so the lowest effective index wins.
    always_comb begin
        rgb_d = BG_RGB;
        win_d = ID_W'(NUM_LAYERS);
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff[i]) begin
                rgb_d = layerRGB[8*i +: 8];
                win_d = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ACCUM;
            rgb_q        <= 8'h00;
            win_q        <= ID_W'(NUM_LAYERS);
            acc_layer_q  <= '0;
            acc_border_q <= '0;
            hit_layer_q  <= '0;
            hit_border_q <= '0;
            pulse_q      <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            rgb_q <= rgb_d;
            win_q <= win_d;

            if (startOfFrame) begin
                // Hand off the finished frame only; this pixel's own hits
                // seed the accumulators of the frame that starts now.
                hit_layer_q  <= acc_layer_q;
                hit_border_q <= acc_border_q;
                acc_layer_q  <= cur_layer_hit;
                acc_border_q <= cur_border_hit;
                fcnt_q       <= fcnt_q + 1'b1;
                pulse_q      <= |{acc_layer_q, acc_border_q};
                state_q      <= HANDOFF;
            end else begin
                acc_layer_q  <= acc_layer_q | cur_layer_hit;
                acc_border_q <= acc_border_q | cur_border_hit;
                pulse_q      <= 1'b0;
                case (state_q)
                    HANDOFF: state_q <= ACCUM;
                    default: state_q <= ACCUM;
                endcase
            end
        end
    end

    assign RGBOut         = rgb_q;
    assign winnerId       = win_q;
    assign layerHitLayer  = hit_layer_q;
    assign layerHitBorder = hit_border_q;
    assign collisionPulse = pulse_q;
    assign frameCount     = fcnt_q;

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// tb/tb_draw_layer_arbiter.sv - self-checking bench for draw_layer_arbiter
module tb_draw_layer_arbiter;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic [3:0]  drawReq;
    logic [31:0] layerRGB;
    logic [7:0]  BG_RGB;
    logic        boardersDrawReq;
    logic [7:0]  RGBOut;
    logic [2:0]  winnerId;
    logic [3:0]  layerHitLayer;
    logic [3:0]  layerHitBorder;
    logic        collisionPulse;
    logic [15:0] frameCount;

    int checks   = 0;
    int failures = 0;

    draw_layer_arbiter dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .drawReq         (drawReq),
        .layerRGB        (layerRGB),
        .BG_RGB          (BG_RGB),
        .boardersDrawReq (boardersDrawReq),
        .RGBOut          (RGBOut),
        .winnerId        (winnerId),
        .layerHitLayer   (layerHitLayer),
        .layerHitBorder  (layerHitBorder),
        .collisionPulse  (collisionPulse),
        .frameCount      (frameCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  dr;
        logic [31:0] rgb;
        logic [7:0]  bg;
        logic        brd;
        logic [7:0]  e_rgb;
        logic [2:0]  e_win;
    } vec_t;

    typedef struct {
        logic [7:0] rgb;
        logic [2:0] win;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[6];

    localparam logic [31:0] COLS = 32'h44332211;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference priority: first effective layer from index 0, else background.
    function automatic exp_t model(input logic [3:0] dr, input logic [31:0] rgb, input logic [7:0] bg);
        exp_t e;
        logic [31:0] r;
        e.rgb = bg;
        e.win = 3'd4;
        r = rgb;
        for (int i = 3; i >= 0; i--) begin
            if (dr[i] && (r[8*i +: 8] != 8'hFF)) begin
                e.rgb = r[8*i +: 8];
                e.win = 3'(i);
            end
        end
        return e;
    endfunction

    // One pixel: drive, record expectation, clock, then compare the produced output.
    task automatic cyc(input logic [3:0] dr, input logic [31:0] rgb, input logic [7:0] bg,
                       input logic brd, input logic sof, input logic [7:0] e_rgb, input logic [2:0] e_win);
        exp_t e, got;
        drawReq         = dr;
        layerRGB        = rgb;
        BG_RGB          = bg;
        boardersDrawReq = brd;
        startOfFrame    = sof;
        e.rgb = e_rgb;
        e.win = e_win;
        exp_q.push_back(e);
        tick();
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            got = exp_q.pop_front();
            chk("RGBOut", {24'h0, RGBOut}, {24'h0, got.rgb});
            chk("winnerId", {29'h0, winnerId}, {29'h0, got.win});
        end
    endtask

    task automatic px(input logic [3:0] dr, input logic [31:0] rgb, input logic brd, input logic sof);
        exp_t e;
        e = model(dr, rgb, 8'h1C);
        cyc(dr, rgb, 8'h1C, brd, sof, e.rgb, e.win);
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] l, input logic [3:0] b,
                             input logic p, input logic [15:0] fc);
        chk({tag, "_layerHitLayer"}, {28'h0, layerHitLayer}, {28'h0, l});
        chk({tag, "_layerHitBorder"}, {28'h0, layerHitBorder}, {28'h0, b});
        chk({tag, "_collisionPulse"}, {31'h0, collisionPulse}, {31'h0, p});
        chk({tag, "_frameCount"}, {16'h0, frameCount}, {16'h0, fc});
    endtask

    initial begin
        vecs[0] = '{dr: 4'b0000, rgb: COLS,         bg: 8'h1C, brd: 1'b0, e_rgb: 8'h1C, e_win: 3'd4};
        vecs[1] = '{dr: 4'b0110, rgb: 32'h0003E000, bg: 8'h1C, brd: 1'b0, e_rgb: 8'hE0, e_win: 3'd1};
        vecs[2] = '{dr: 4'b1001, rgb: 32'h550000FF, bg: 8'h1C, brd: 1'b0, e_rgb: 8'h55, e_win: 3'd3};
        vecs[3] = '{dr: 4'b1111, rgb: COLS,         bg: 8'h1C, brd: 1'b0, e_rgb: 8'h11, e_win: 3'd0};
        vecs[4] = '{dr: 4'b1000, rgb: 32'hFF000000, bg: 8'h2A, brd: 1'b0, e_rgb: 8'h2A, e_win: 3'd4};
        vecs[5] = '{dr: 4'b0100, rgb: 32'h00AA0000, bg: 8'h1C, brd: 1'b1, e_rgb: 8'hAA, e_win: 3'd2};

        resetN = 1'b0; startOfFrame = 1'b0; drawReq = '0; layerRGB = COLS;
        BG_RGB = 8'h1C; boardersDrawReq = 1'b0;
        tick(); tick();
        chk("reset_RGBOut", {24'h0, RGBOut}, 32'h0);
        chk("reset_winnerId", {29'h0, winnerId}, 32'd4);
        chk_flags("reset", 4'b0, 4'b0, 1'b0, 16'd0);
        resetN = 1'b1;

        for (int i = 0; i < 6; i++)
            cyc(vecs[i].dr, vecs[i].rgb, vecs[i].bg, vecs[i].brd, 1'b0, vecs[i].e_rgb, vecs[i].e_win);
        chk_flags("pre_first_sof", 4'b0, 4'b0, 1'b0, 16'd0);

        // Table pixels: 0110 and 1111 overlaps, layer 2 on a border.
        px(4'b0000, COLS, 1'b0, 1'b1);
        chk_flags("table_frame", 4'b1111, 4'b0100, 1'b1, 16'd1);
        px(4'b0000, COLS, 1'b0, 1'b0);
        chk("table_pulse_drop", {31'h0, collisionPulse}, 32'h0);

        // Transparent layer 0 with layer 3: no overlap recorded.
        px(4'b1001, 32'h550000FF, 1'b0, 1'b0);
        px(4'b0000, COLS, 1'b0, 1'b1);
        chk_flags("transparent", 4'b0, 4'b0, 1'b0, 16'd2);

        // Single overlap of layers 0 and 2.
        px(4'b0101, COLS, 1'b0, 1'b0);
        px(4'b0000, COLS, 1'b0, 1'b0);
        px(4'b0000, COLS, 1'b0, 1'b1);
        chk_flags("overlap02", 4'b0101, 4'b0, 1'b1, 16'd3);
        px(4'b0000, COLS, 1'b0, 1'b0);
        chk("overlap02_pulse_drop", {31'h0, collisionPulse}, 32'h0);
        chk("overlap02_hold", {28'h0, layerHitLayer}, 32'h5);

        // Border hit on the startOfFrame pixel belongs to the next frame.
        px(4'b0010, COLS, 1'b1, 1'b1);
        chk_flags("border_on_sof", 4'b0, 4'b0, 1'b0, 16'd4);
        px(4'b0000, COLS, 1'b0, 1'b0);
        px(4'b0000, COLS, 1'b0, 1'b1);
        chk_flags("border_next", 4'b0, 4'b0010, 1'b1, 16'd5);

        // Back-to-back startOfFrame: pulse stays high on nonzero new flags.
        px(4'b0011, COLS, 1'b0, 1'b0);
        px(4'b1100, COLS, 1'b0, 1'b1);
        chk_flags("b2b_first", 4'b0011, 4'b0, 1'b1, 16'd6);
        px(4'b0000, COLS, 1'b0, 1'b1);
        chk_flags("b2b_second", 4'b1100, 4'b0, 1'b1, 16'd7);
        px(4'b0000, COLS, 1'b0, 1'b0);
        chk("b2b_pulse_drop", {31'h0, collisionPulse}, 32'h0);

        // Mid-frame reset discards partial hits and clears everything at once.
        px(4'b1111, COLS, 1'b1, 1'b0);
        resetN = 1'b0;
        #1;
        chk("midreset_RGBOut", {24'h0, RGBOut}, 32'h0);
        chk("midreset_winnerId", {29'h0, winnerId}, 32'd4);
        chk_flags("midreset", 4'b0, 4'b0, 1'b0, 16'd0);
        tick(); tick();
        resetN = 1'b1;
        exp_q.delete();
        px(4'b0000, COLS, 1'b0, 1'b0);
        px(4'b0000, COLS, 1'b0, 1'b0);
        px(4'b0000, COLS, 1'b0, 1'b1);
        chk_flags("post_reset_frame", 4'b0, 4'b0, 1'b0, 16'd1);

        // Drive frame counter to all-ones, then wrap.
        drawReq = '0; boardersDrawReq = 1'b0; startOfFrame = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        chk("fc_allones", {16'h0, frameCount}, 32'hFFFF);
        tick();
        chk("fc_wrap", {16'h0, frameCount}, 32'h0);
        chk("fc_wrap_pulse", {31'h0, collisionPulse}, 32'h0);
        startOfFrame = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
